// File: rtl/mano_io_pkg.sv
// Shared types for the Mano terminal model: FSM state encodings and default character width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mano_io_pkg;

  localparam int CHAR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    I_IDLE,
    I_GAP,
    I_PRESENT,
    I_WAIT
  } in_state_t;

  typedef enum logic [1:0] {
    O_WAIT,
    O_IDLE,
    O_DELAY,
    O_CAPTURE
  } out_state_t;

endpackage

// File: rtl/mano_char_fifo.sv
// Synchronous show-ahead character FIFO; the head entry is always visible on head.
// Latency: a write becomes visible on head/empty one cycle after the push edge.
// Backpressure: a push while full is dropped unless a pop frees the entry in the same cycle.
module mano_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra top bit distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mano_io_stim.sv
// Terminal model for the Mano machine: paced keyboard source on INPR/FGI, printer sink on OUTR/FGO.
// Latency: push to FGI set pulse is io_gap+3 cycles; FGO low to FGO set pulse is OUT_DELAY+1 cycles.
// Backpressure: io_load_ready drops when the input queue is full; a full capture queue holds the printer in capture, withholding the FGO set.
module mano_io_stim
  import mano_io_pkg::*;
#(
  parameter int CHAR_WIDTH = CHAR_WIDTH_DEF,
  parameter int IN_DEPTH   = 16,
  parameter int CAP_DEPTH  = 16,
  parameter int GAP_W      = 8,
  parameter int OUT_DELAY  = 4
) (
  input  logic                  io_clock,
  input  logic                  io_reset_n,
  input  logic                  io_load_valid,
  input  logic [CHAR_WIDTH-1:0] io_load_data,
  output logic                  io_load_ready,
  input  logic [GAP_W-1:0]      io_gap,
  input  logic                  io_fgi,
  output logic                  io_fgiset,
  output logic [CHAR_WIDTH-1:0] io_inpr,
  input  logic                  io_fgo,
  input  logic [CHAR_WIDTH-1:0] io_outr,
  output logic                  io_fgoset,
  output logic                  io_cap_valid,
  output logic [CHAR_WIDTH-1:0] io_cap_data,
  input  logic                  io_cap_ready,
  output logic                  io_in_empty
);

  localparam int DW = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_LOAD = DW'(OUT_DELAY - 1);

  // ---------------- keyboard side ----------------
  in_state_t             in_state;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  in_full;
  logic                  in_empty_q;
  logic [CHAR_WIDTH-1:0] in_head;
  logic                  in_push;
  logic                  in_pop;

  assign io_load_ready = !in_full;
  assign in_push       = io_load_valid && !in_full;
  // The head is consumed in the same cycle it is latched onto INPR.
  assign in_pop        = (in_state == I_PRESENT);
  assign io_in_empty   = in_empty_q && (in_state == I_IDLE);

  mano_char_fifo #(
    .WIDTH (CHAR_WIDTH),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk       (io_clock),
    .rst_n     (io_reset_n),
    .push      (in_push),
    .push_data (io_load_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty_q)
  );

  // Keyboard pacing FSM: wait for FGI clear, idle io_gap cycles, present one character with an FGI set pulse.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      in_state  <= I_IDLE;
      gap_cnt   <= '0;
      io_inpr   <= '0;
      io_fgiset <= 1'b0;
    end else begin
      io_fgiset <= 1'b0;
      case (in_state)
        I_IDLE: begin
          if (!in_empty_q && !io_fgi) begin
            gap_cnt  <= io_gap;
            in_state <= I_GAP;
          end
        end
        I_GAP: begin
          if (gap_cnt == '0) begin
            in_state <= I_PRESENT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        I_PRESENT: begin
          io_inpr   <= in_head;
          io_fgiset <= 1'b1;
          in_state  <= I_WAIT;
        end
        I_WAIT: begin
          if (io_fgi) begin
            in_state <= I_IDLE;
          end
        end
        default: in_state <= I_IDLE;
      endcase
    end
  end

  // ---------------- printer side ----------------
  out_state_t            out_state;
  logic [DW-1:0]         dly_cnt;
  logic                  cap_full;
  logic                  cap_empty;
  logic                  cap_pop;
  logic                  cap_ok;
  logic                  cap_wr;
  logic [CHAR_WIDTH-1:0] cap_wr_data;

  assign io_cap_valid = !cap_empty;
  assign cap_pop      = io_cap_valid && io_cap_ready;
  // A pop in the same cycle frees the slot the pending character will land in.
  assign cap_ok       = !cap_full || cap_pop;

  mano_char_fifo #(
    .WIDTH (CHAR_WIDTH),
    .DEPTH (CAP_DEPTH)
  ) u_cap_fifo (
    .clk       (io_clock),
    .rst_n     (io_reset_n),
    .push      (cap_wr),
    .push_data (cap_wr_data),
    .pop       (cap_pop),
    .head      (io_cap_data),
    .full      (cap_full),
    .empty     (cap_empty)
  );

  // Printer FSM: arm on FGO high, count the busy delay after FGO falls, then capture OUTR and pulse FGO set.
  // The captured character is written one cycle after the pulse so it shows up the cycle after FGO set.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      out_state   <= O_WAIT;
      dly_cnt     <= '0;
      io_fgoset   <= 1'b0;
      cap_wr      <= 1'b0;
      cap_wr_data <= '0;
    end else begin
      io_fgoset <= 1'b0;
      cap_wr    <= 1'b0;
      case (out_state)
        O_WAIT: begin
          if (io_fgo) begin
            out_state <= O_IDLE;
          end
        end
        O_IDLE: begin
          if (!io_fgo) begin
            dly_cnt   <= DELAY_LOAD;
            out_state <= O_DELAY;
          end
        end
        O_DELAY: begin
          if (dly_cnt == '0) begin
            out_state <= O_CAPTURE;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        O_CAPTURE: begin
          if (cap_ok) begin
            cap_wr      <= 1'b1;
            cap_wr_data <= io_outr;
            io_fgoset   <= 1'b1;
            out_state   <= O_WAIT;
          end
        end
        default: out_state <= O_WAIT;
      endcase
    end
  end

endmodule
